// File: rtl/add_seq_arb.sv
// ---------------------------------------------------------------------------
// add_seq_arb -- shared-adder sequencer and two-way round-robin arbiter.
//
// Two requesters share a single 4-bit carry-lookahead adder (cla4). Each
// granted operation adds two W = NIB*4 bit unsigned operands plus a carry-in,
// one nibble per clock, least-significant nibble first, with the inter-nibble
// carry held in a register.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   req{0,1}_i       level request, held until the matching done pulse
//   a{0,1}_i         operand A (W bits)
//   b{0,1}_i         operand B (W bits)
//   ci{0,1}_i        carry-in
//   gnt{0,1}_o       requester owns the adder (ADD and DONE cycles)
//   busy_o           gnt0_o | gnt1_o
//   done{0,1}_o      one-cycle pulse, result on s_o/co_o is valid
//   s_o              sum of the last completed operation (held)
//   co_o             carry-out of bit W-1 of the last completed operation
// ---------------------------------------------------------------------------

// 4-bit carry-lookahead adder: all carries computed in parallel from
// generate/propagate terms.
module cla4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       ci_i,
    output logic [3:0] s_o,
    output logic       co_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    assign c[0] = ci_i;
    assign c[1] = g[0] | (p[0] & ci_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci_i);
    assign co_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci_i);

    assign s_o = p ^ c;
endmodule

module add_seq_arb #(
    parameter int NIB = 4,
    parameter int W   = NIB * 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req0_i,
    input  logic [W-1:0] a0_i,
    input  logic [W-1:0] b0_i,
    input  logic         ci0_i,
    input  logic         req1_i,
    input  logic [W-1:0] a1_i,
    input  logic [W-1:0] b1_i,
    input  logic         ci1_i,
    output logic         gnt0_o,
    output logic         gnt1_o,
    output logic         busy_o,
    output logic         done0_o,
    output logic         done1_o,
    output logic [W-1:0] s_o,
    output logic         co_o
);
    localparam int IDXW = (NIB <= 2) ? 1 : $clog2(NIB);
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   own_q,   own_d;    // which requester holds the grant
    logic                   rr_q,    rr_d;     // requester favoured on a tie
    logic [NIB-1:0][3:0]    a_q,     a_d;
    logic [NIB-1:0][3:0]    b_q,     b_d;
    logic [NIB-1:0][3:0]    res_q,   res_d;
    logic [IDXW-1:0]        idx_q,   idx_d;
    logic                   carry_q, carry_d;
    logic [W-1:0]           s_q,     s_d;
    logic                   co_q,    co_d;

    logic [3:0]             nib_s;
    logic                   nib_co;
    logic                   pick;

    cla4 u_cla4 (
        .a_i  (a_q[idx_q]),
        .b_i  (b_q[idx_q]),
        .ci_i (carry_q),
        .s_o  (nib_s),
        .co_o (nib_co)
    );

    // On a tie the pointer decides; otherwise the lone requester wins.
    assign pick = (req0_i & req1_i) ? rr_q : req1_i;

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        rr_d    = rr_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        s_d     = s_q;
        co_d    = co_q;

        case (state_q)
            IDLE: begin
                if (req0_i | req1_i) begin
                    own_d   = pick;
                    a_d     = pick ? a1_i  : a0_i;
                    b_d     = pick ? b1_i  : b0_i;
                    carry_d = pick ? ci1_i : ci0_i;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                res_d[idx_q] = nib_s;
                carry_d      = nib_co;
                idx_d        = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    // Publish on the edge into DONE so s/co are already
                    // valid during the done cycle.
                    s_d     = res_d;
                    co_d    = nib_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                rr_d    = ~own_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            own_q   <= 1'b0;
            rr_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            rr_q    <= rr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            co_q    <= co_d;
        end
    end

    assign gnt0_o  = (state_q != IDLE) & ~own_q;
    assign gnt1_o  = (state_q != IDLE) &  own_q;
    assign busy_o  = gnt0_o | gnt1_o;
    assign done0_o = (state_q == DONE) & ~own_q;
    assign done1_o = (state_q == DONE) &  own_q;
    assign s_o     = s_q;
    assign co_o    = co_q;
endmodule
